// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock supervisor with retry and sticky fault
// Build option PLL_SUP_RELOCK_EN: lock loss in RUN re-acquires instead of faulting.
module pll_lock_supervisor #(
  parameter int RST_PULSE    = 32,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int MAX_A = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  state_t        state_q, state_d;
  logic          sync_q, locked_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic          pll_rst_q, pll_rst_d;
  logic          ready_q, ready_d;
  logic          lock_lost_q, lock_lost_d;
  logic          fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // lock seen on the timeout cycle takes priority over the retry
        if (locked_s_q) begin
          state_d = STABILIZE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = RESET_PLL;
          end
        end
      end
      STABILIZE: begin
        if (!locked_s_q)                 state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)   state_d = RUN;
      end
      RUN: begin
        if (!locked_s_q) begin
`ifdef PLL_SUP_RELOCK_EN
          state_d = RESET_PLL;
`else
          state_d = FAULT;
`endif
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    if (state_d == RUN || (state_q == RUN && state_d == RESET_PLL)) retry_d = 2'd0;

    // the counter is idle in RUN/FAULT so it never wraps there
    if (state_d != state_q || state_q == RUN || state_q == FAULT) cnt_d = '0;
    else                                                          cnt_d = cnt_q + CW'(1);

    pll_rst_d   = (state_d == RESET_PLL);
    ready_d     = (state_d == RUN);
    lock_lost_d = (state_q == RUN) && !locked_s_q;
    // a fault caused by lock loss shows one edge after the lock_lost pulse
    fault_d     = (state_d == FAULT) && (state_q != RUN);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      sync_q      <= 1'b0;
      locked_s_q  <= 1'b0;
      cnt_q       <= '0;
      retry_q     <= 2'd0;
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= pll_locked;
      locked_s_q  <= sync_q;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
// Expected output changes are derived from edge arithmetic; define PLL_SUP_RELOCK_EN to match the DUT build.
module tb_pll_lock_supervisor;
  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 16;
  localparam int MR = 2;
  localparam int AT = RP + LT;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, ready, lock_lost, fault;
  logic [1:0] retry_cnt;

  pll_lock_supervisor #(
    .RST_PULSE(RP), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .ready(ready), .lock_lost(lock_lost),
    .fault(fault), .retry_cnt(retry_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    int         e;
    logic [5:0] v;
  } ev_t;

  ev_t        sb[$];
  ev_t        mx;
  int         ecnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic [5:0] prev_v = 6'b100000;
  wire  [5:0] cur_v = {pll_rst, ready, lock_lost, fault, retry_cnt};

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  // monitor: every change of the output vector must match the next expected event
  always @(negedge refclk) begin
    if (!rst_n) begin
      prev_v = 6'b100000;
    end else if (cur_v !== prev_v) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge=%0d got vec=%b, required no change", ecnt, cur_v);
      end else begin
        mx = sb.pop_front();
        if (mx.e != ecnt || mx.v !== cur_v) begin
          errors++;
          $display("FAIL event edge=%0d vec=%b, required edge=%0d vec=%b", ecnt, cur_v, mx.e, mx.v);
        end
      end
      prev_v = cur_v;
    end else if (sb.size() > 0 && sb[0].e < ecnt) begin
      checks++;
      errors++;
      mx = sb.pop_front();
      $display("FAIL missed_event at edge=%0d vec=%b, required edge=%0d vec=%b", ecnt, cur_v, mx.e, mx.v);
    end
  end

  task automatic push(input int e, input bit r, input bit rdy, input bit ll, input bit f, input bit [1:0] rc);
    ev_t x;
    x.e = e;
    x.v = {r, rdy, ll, f, rc};
    sb.push_back(x);
  endtask

  task automatic goto_edge(input int n);
    while (ecnt < n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // value is first sampled by the DUT at edge n
  task automatic set_lock_at(input int n, input bit val);
    goto_edge(n - 1);
    pll_locked = val;
  endtask

  task automatic do_reset();
    @(posedge refclk);
    #3;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    #1;
    checks++;
    if (cur_v !== 6'b100000) begin
      errors++;
      $display("FAIL reset_values got vec=%b, required vec=100000", cur_v);
    end
    sb.delete();
    repeat (2) @(negedge refclk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k, d, g, h, m, n, n2, r, last, base;
    bit glitch;
    for (int it = 0; it < 14; it++) begin
      do_reset();
      k      = $urandom_range(0, MR + 1);
      d      = $urandom_range(1, LT - 2);
      glitch = 1'($urandom_range(0, 1));
      g      = $urandom_range(1, LS);
      if (it == 0) begin k = 0; d = 5; glitch = 1'b0; end
      if (it == 1) begin k = 0; d = 5; glitch = 1'b1; g = 5; end
      if (it == 2) k = MR + 1;
      if (it == 3) begin k = 1; d = LT - 2; glitch = 1'b0; end

      for (int j = 0; j < k; j++) begin
        base = j * AT;
        push(base + RP, 0, 0, 0, 0, 2'(j));
        if (j < MR) push(base + AT, 1, 0, 0, 0, 2'(j + 1));
        else        push(base + AT, 0, 0, 0, 1, 2'(j));
      end

      if (k == MR + 1) begin
        // fault is terminal: a late lock must not change anything
        n = (MR + 1) * AT + $urandom_range(2, 10);
        set_lock_at(n, 1'b1);
        last = n + LS + 10;
      end else begin
        base = k * AT;
        push(base + RP, 0, 0, 0, 0, 2'(k));
        n = base + RP + d;
        r = glitch ? (n + g + 3 + LS) : (n + 2 + LS);
        push(r, 0, 1, 0, 0, 2'd0);
        h = $urandom_range(1, 10);
        m = r + h;
`ifdef PLL_SUP_RELOCK_EN
        push(m + 2, 1, 0, 1, 0, 2'd0);
        push(m + 3, 1, 0, 0, 0, 2'd0);
        push(m + 2 + RP, 0, 0, 0, 0, 2'd0);
        n2 = m + 2 + RP + $urandom_range(1, LT - 2);
        push(n2 + 2 + LS, 0, 1, 0, 0, 2'd0);
        last = n2 + 2 + LS;
`else
        push(m + 2, 0, 0, 1, 0, 2'd0);
        push(m + 3, 0, 0, 0, 1, 2'd0);
        n2 = m + 3 + $urandom_range(1, 8);
        last = n2 + LS + 10;
`endif
        set_lock_at(n, 1'b1);
        if (glitch) begin
          set_lock_at(n + g, 1'b0);
          set_lock_at(n + g + 1, 1'b1);
        end
        set_lock_at(m, 1'b0);
        set_lock_at(n2, 1'b1);
      end

      goto_edge(last + 4);
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL pending_events iter=%0d got %0d left, required 0", it, sb.size());
      end
    end
    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Reset/lock supervisor for the system PLL wrapper. It runs on the PLL reference clock and drives the PLL's active-high reset input. It consumes the PLL's asynchronous locked output and produces a clean, debounced `ready` for the core reset tree. It also retries lock acquisition and reports a sticky fault when the PLL never locks.

## Interface
Parameters:
- `RST_PULSE`, default 32: refclk cycles `pll_rst` is held high per reset attempt; must be ≥ 1.
- `LOCK_STABLE`, default 1024: consecutive synchronized-locked cycles required before `ready`; must be ≥ 1.
- `LOCK_TIMEOUT`, default 65536: refclk cycles waited for lock per attempt; must be ≥ 1.
- `MAX_RETRIES`, default 3: extra reset attempts before fault; range 0–3.

Ports:
- `refclk` in 1: 50 MHz reference clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL locked, asynchronous to refclk.
- `pll_rst` out 1: active-high reset to the PLL.
- `ready` out 1: PLL clocks stable; the core may leave reset.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `fault` out 1: sticky; the PLL failed to lock after all retries.
- `retry_cnt` out 2: number of retries used in the current acquisition.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset to 0) to give `locked_s`. All decisions use `locked_s` only.
- One shared cycle counter `cnt` is used. Its width is `$clog2` of the largest of the three cycle parameters, plus 1. `cnt` clears on every state change.
- FSM states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT.
- **RESET_PLL**
  - `pll_rst`=1.
  - When `cnt`==RST_PULSE-1, go to WAIT_LOCK.
- **WAIT_LOCK**
  - `pll_rst`=0.
  - If `locked_s`=1, go to STABILIZE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT-1:
    - if `retry_cnt`==MAX_RETRIES, go to FAULT;
    - else increment `retry_cnt` and go to RESET_PLL.
  - If lock arrives on the timeout cycle, lock wins.
- **STABILIZE**
  - If `locked_s`=0, return to WAIT_LOCK; the timeout window restarts from 0.
  - When `cnt`==LOCK_STABLE-1 with `locked_s`=1, go to RUN.
- **RUN**
  - `ready`=1. `retry_cnt` clears on entry.
  - If `locked_s`=0: pulse `lock_lost` and clear `ready` on the same edge, then take the lock-loss action described under Configuration.
- **FAULT**
  - `pll_rst`=0, `fault`=1, `ready`=0.
  - Terminal: only `rst_n` exits.
- All outputs are registered. There are no combinational paths from input to output.
- Reset values:
  - FSM state = RESET_PLL;
  - `pll_rst`=1;
  - `ready`=0, `lock_lost`=0, `fault`=0;
  - `retry_cnt`=0, `cnt`=0.
- Asserting `rst_n` mid-operation, including in RUN or FAULT, immediately forces all reset values. `pll_rst` goes high asynchronously.

## Timing
- After `rst_n` deasserts, `pll_rst` stays high for exactly RST_PULSE refclk edges.
- Ready latency, with `pll_locked` first sampled high at edge N and held:
  - `locked_s`=1 after edge N+1;
  - STABILIZE is entered after edge N+2;
  - `ready`=1 after edge N+2+LOCK_STABLE.
- Lock loss: `pll_locked` falls before edge M. After edge M+2, `ready`=0 and `lock_lost`=1 for one cycle.
- A glitch on `locked_s` shorter than LOCK_STABLE cycles during STABILIZE never produces `ready`.
- A never-locking PLL is declared faulted after (MAX_RETRIES+1)×(RST_PULSE+LOCK_TIMEOUT) cycles from reset release.

## Configuration
- Macro: `PLL_SUP_RELOCK_EN`.
- Defined: lock loss in RUN goes to RESET_PLL with `retry_cnt`=0, starting a full re-acquisition including retries.
- Undefined: lock loss in RUN goes to FAULT. `fault`=1 on the edge after the `lock_lost` pulse; sticky.
- `lock_lost` and `ready` timing are identical in both builds.

## Test plan
All scenarios use RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=16, MAX_RETRIES=2.
1. **Reset values:** assert `rst_n`=0 → `pll_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0. Release `rst_n` → `pll_rst` falls after exactly 4 edges.
2. **Clean lock:** `pll_locked` rises 5 cycles after `pll_rst` falls and stays high → `ready`=1 exactly 10 edges after the first high sample; `retry_cnt`=0.
3. **Glitch rejection:** `pll_locked` high for 5 cycles, low for 1, then high → `ready` is counted from the second rise (10 edges); no `lock_lost` pulse.
4. **Retry/fault:** hold `pll_locked`=0 → `retry_cnt` steps 1, 2 with `pll_rst` pulses of 4 cycles. `fault`=1 after 60 cycles from reset release. `fault` stays high until `rst_n` is asserted.
5. **Lock loss with `PLL_SUP_RELOCK_EN`:** in RUN, drop `pll_locked` → `lock_lost` is a 1-cycle pulse and `ready`=0 at edge +2. `pll_rst` pulses for 4 cycles; relock gives `ready` again.
6. **Lock loss without the macro:** same stimulus as 5 → `fault`=1 one edge after `lock_lost`. `pll_rst` stays 0; `ready` stays 0 even if `pll_locked` returns.
